// File: rtl/mem_op_pkg.sv
// Shared load/store encodings for the control unit and the data-memory responder.
//   mem_size_t    : funct3 access size / signedness encodings
//   mem_state_t   : responder FSM states
//   LOAD_OPCODE / STORE_OPCODE : major opcodes that raise MemRead / MemWrite
//   req_error()   : misalignment / illegal-funct3 / read+write check
//   load_extend() : lane select and sign/zero extension of a loaded word
package mem_op_pkg;

  typedef enum logic [2:0] {
    MEM_B  = 3'b000,
    MEM_H  = 3'b001,
    MEM_W  = 3'b010,
    MEM_BU = 3'b100,
    MEM_HU = 3'b101
  } mem_size_t;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    RESP   = 2'd2
  } mem_state_t;

  localparam logic [6:0] LOAD_OPCODE  = 7'b0000011;
  localparam logic [6:0] STORE_OPCODE = 7'b0100011;

  function automatic logic req_error(input logic rd, input logic wr,
                                     input logic [2:0] f3, input logic [1:0] lo);
    logic bad_f3;
    logic misal;
    if (wr) bad_f3 = f3[2] || (f3 == 3'b011);
    else    bad_f3 = (f3 == 3'b011) || (f3 == 3'b110) || (f3 == 3'b111);
    misal = ((f3[1:0] == 2'b01) && lo[0]) || ((f3[1:0] == 2'b10) && (lo != 2'b00));
    return (rd && wr) || bad_f3 || misal;
  endfunction

  // Shifting the word right by the byte offset puts the addressed byte (or the
  // aligned half) in the low lanes for every legal access.
  function automatic logic [31:0] load_extend(input logic [2:0] f3, input logic [1:0] lo,
                                              input logic [31:0] word);
    logic [31:0] sh;
    sh = word >> {lo, 3'b000};
    case (mem_size_t'(f3))
      MEM_B:   return {{24{sh[7]}}, sh[7:0]};
      MEM_BU:  return {24'b0, sh[7:0]};
      MEM_H:   return {{16{sh[15]}}, sh[15:0]};
      MEM_HU:  return {16'b0, sh[15:0]};
      default: return word;
    endcase
  endfunction

endpackage

// File: rtl/data_mem_responder_if.sv
// Load/store bus between the control unit (master) and the data memory (slave).
//   MemRead/MemWrite/funct3/addr/wdata : request from the core
//   rdata/stall/done/fault             : response to the core
interface data_mem_responder_if;
  logic        MemRead;
  logic        MemWrite;
  logic [2:0]  funct3;
  logic [31:0] addr;
  logic [31:0] wdata;
  logic [31:0] rdata;
  logic        stall;
  logic        done;
  logic        fault;

  modport master (output MemRead, MemWrite, funct3, addr, wdata,
                  input  rdata, stall, done, fault);
  modport slave  (input  MemRead, MemWrite, funct3, addr, wdata,
                  output rdata, stall, done, fault);
endinterface

// File: rtl/byte_en_ram.sv
// Single-port synchronous RAM, 4 byte lanes, registered read-first output.
//   clk   : clock
//   en    : access enable (read and/or write this edge)
//   we    : per-lane write enables
//   addr  : word index
//   wdata : write data (lane i = wdata[8i+7:8i])
//   q     : registered read data
module byte_en_ram #(
  parameter int DEPTH_WORDS = 1024,
  localparam int AW = $clog2(DEPTH_WORDS)
) (
  input  logic          clk,
  input  logic          en,
  input  logic [3:0]    we,
  input  logic [AW-1:0] addr,
  input  logic [31:0]   wdata,
  output logic [31:0]   q
);

  logic [31:0] mem [DEPTH_WORDS];

  always_ff @(posedge clk) begin
    if (en) begin
      for (int i = 0; i < 4; i++) begin
        if (we[i]) mem[addr][8*i +: 8] <= wdata[8*i +: 8];
      end
      q <= mem[addr];
    end
  end

endmodule

// File: rtl/data_mem_responder.sv
// Data-memory responder: accepts a load/store from the control unit, performs
// it on a byte-enabled RAM after WAIT_STATES extra cycles and answers with a
// one-cycle done pulse (fault-qualified) while holding the core via stall.
//   clk, rst : clock, asynchronous active-high reset
//   bus      : slave side of data_mem_responder_if
module data_mem_responder
  import mem_op_pkg::*;
#(
  parameter int DEPTH_WORDS = 1024,
  parameter int WAIT_STATES = 0
) (
  input logic                  clk,
  input logic                  rst,
  data_mem_responder_if.slave  bus
);

  localparam int IDX_W = $clog2(DEPTH_WORDS);

  mem_state_t  state;
  mem_state_t  state_nxt;
  logic [3:0]  cnt;
  logic        err_q;
  logic        store_q;
  logic [2:0]  f3_q;
  logic [31:0] addr_q;
  logic [31:0] wdata_q;
  logic [31:0] rdata_hold;

  logic        req;
  logic        cap_err;
  logic        ram_en;
  logic [3:0]  be;
  logic [3:0]  ram_we;
  logic [31:0] ram_wdata;
  logic [31:0] ram_q;
  logic [31:0] resp_data;
  logic        unused_addr_hi;

  assign req     = bus.MemRead | bus.MemWrite;
  assign cap_err = req_error(bus.MemRead, bus.MemWrite, bus.funct3, bus.addr[1:0]);

  // Capture stage: control state
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= IDLE;
      cnt        <= 4'd0;
      err_q      <= 1'b0;
      store_q    <= 1'b0;
      rdata_hold <= 32'd0;
    end else begin
      state <= state_nxt;
      case (state)
        IDLE: if (req) begin
          cnt     <= 4'(WAIT_STATES);
          err_q   <= cap_err;
          store_q <= bus.MemWrite;
        end
        ACCESS: if (cnt != 4'd0) cnt <= cnt - 4'd1;
        RESP:   rdata_hold <= resp_data;
        default: ;
      endcase
    end
  end

  // Capture stage: request payload
  always_ff @(posedge clk) begin
    if (state == IDLE && req) begin
      f3_q    <= bus.funct3;
      addr_q  <= bus.addr;
      wdata_q <= bus.wdata;
    end
  end

  always_comb begin
    state_nxt = state;
    bus.stall = 1'b0;
    bus.done  = 1'b0;
    bus.fault = 1'b0;
    ram_en    = 1'b0;
    case (state)
      IDLE: begin
        bus.stall = req;
        if (req) state_nxt = cap_err ? RESP : ACCESS;
      end
      ACCESS: begin
        bus.stall = 1'b1;
        if (cnt == 4'd0) begin
          ram_en    = 1'b1;
          state_nxt = RESP;
        end
      end
      RESP: begin
        bus.done  = 1'b1;
        bus.fault = err_q;
        state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Store lanes: narrow data is replicated so the enabled lane always sees it.
  always_comb begin
    be        = 4'b1111;
    ram_wdata = wdata_q;
    case (f3_q[1:0])
      2'b00: begin
        be        = 4'b0001 << addr_q[1:0];
        ram_wdata = {4{wdata_q[7:0]}};
      end
      2'b01: begin
        be        = 4'b0011 << addr_q[1:0];
        ram_wdata = {2{wdata_q[15:0]}};
      end
      default: ;
    endcase
  end

  // Faulted requests never reach ACCESS, so ram_en alone keeps them out of the RAM.
  assign ram_we = store_q ? be : 4'b0000;

  // Access stage: RAM
  byte_en_ram #(.DEPTH_WORDS(DEPTH_WORDS)) u_ram (
    .clk   (clk),
    .en    (ram_en),
    .we    (ram_we),
    .addr  (addr_q[IDX_W+1:2]),
    .wdata (ram_wdata),
    .q     (ram_q)
  );

  // Response stage: extension and hold
  assign resp_data = (err_q || store_q) ? 32'd0 : load_extend(f3_q, addr_q[1:0], ram_q);
  assign bus.rdata = (state == RESP) ? resp_data : rdata_hold;

  // Address bits above the RAM index wrap and are intentionally ignored.
  assign unused_addr_hi = ^addr_q[31:IDX_W+2];

endmodule

// File: tb/tb_data_mem_responder.sv
module tb_data_mem_responder;
  import mem_op_pkg::*;

  logic clk = 1'b0;
  logic rst0;
  logic rst3;
  always #5 clk = ~clk;

  data_mem_responder_if bus0();
  data_mem_responder_if bus3();

  logic        mr [2];
  logic        mw [2];
  logic [2:0]  f3 [2];
  logic [31:0] ad [2];
  logic [31:0] wd [2];

  assign bus0.MemRead  = mr[0];
  assign bus0.MemWrite = mw[0];
  assign bus0.funct3   = f3[0];
  assign bus0.addr     = ad[0];
  assign bus0.wdata    = wd[0];
  assign bus3.MemRead  = mr[1];
  assign bus3.MemWrite = mw[1];
  assign bus3.funct3   = f3[1];
  assign bus3.addr     = ad[1];
  assign bus3.wdata    = wd[1];

  data_mem_responder #(.DEPTH_WORDS(1024), .WAIT_STATES(0)) dut0 (
    .clk(clk), .rst(rst0), .bus(bus0));
  data_mem_responder #(.DEPTH_WORDS(1024), .WAIT_STATES(3)) dut3 (
    .clk(clk), .rst(rst3), .bus(bus3));

  typedef struct {
    logic [31:0] rdata;
    logic        fault;
    int          cyc;
    string       name;
  } exp_t;

  exp_t q0[$];
  exp_t q1[$];
  int checks = 0;
  int errors = 0;
  int cyc = 0;

  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic dn(int i);
    return (i == 0) ? bus0.done : bus3.done;
  endfunction

  function automatic logic st(int i);
    return (i == 0) ? bus0.stall : bus3.stall;
  endfunction

  task automatic check(string name, logic [31:0] act, logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=%h required=%h", name, act, req);
    end
  endtask

  task automatic mon(int idx, logic [31:0] rd, logic f, logic s);
    exp_t e;
    checks++;
    if ((idx == 0 && q0.size() == 0) || (idx == 1 && q1.size() == 0)) begin
      errors++;
      $display("FAIL unexpected_done dev%0d actual=done required=no_done cyc=%0d", idx, cyc);
      return;
    end
    if (idx == 0) e = q0.pop_front();
    else          e = q1.pop_front();
    check({e.name, "_rdata"}, rd, e.rdata);
    check({e.name, "_fault"}, {31'b0, f}, {31'b0, e.fault});
    check({e.name, "_done_cycle"}, cyc, e.cyc);
    check({e.name, "_stall_at_done"}, {31'b0, s}, 32'd0);
  endtask

  // Monitor: compares every done pulse against the scoreboard.
  always @(negedge clk) begin
    if (bus0.done) mon(0, bus0.rdata, bus0.fault, bus0.stall);
    if (bus3.done) mon(1, bus3.rdata, bus3.fault, bus3.stall);
  end

  task automatic req(int idx, string name, logic r, logic w, logic [2:0] f,
                     logic [31:0] a, logic [31:0] d, logic [31:0] exp_rd, logic exp_f);
    exp_t e;
    bit   got;
    int   lat;
    @(negedge clk);
    mr[idx] = r; mw[idx] = w; f3[idx] = f; ad[idx] = a; wd[idx] = d;
    #1;
    check({name, "_stall_req"}, {31'b0, st(idx)}, 32'd1);
    lat = exp_f ? 1 : ((idx == 0) ? 0 : 3) + 2;
    e.rdata = exp_rd; e.fault = exp_f; e.cyc = cyc + lat; e.name = name;
    if (idx == 0) q0.push_back(e);
    else          q1.push_back(e);
    got = 0;
    for (int k = 0; k < 40; k++) begin
      @(negedge clk);
      if (dn(idx)) begin
        got = 1;
        break;
      end
      check({name, "_stall_hold"}, {31'b0, st(idx)}, 32'd1);
    end
    mr[idx] = 1'b0; mw[idx] = 1'b0;
    if (!got) begin
      checks++; errors++;
      $display("FAIL %s_timeout actual=no_done required=done", name);
    end
  endtask

  initial begin
    for (int i = 0; i < 2; i++) begin
      mr[i] = 1'b0; mw[i] = 1'b0; f3[i] = 3'b000; ad[i] = 32'd0; wd[i] = 32'd0;
    end
    rst0 = 1'b1; rst3 = 1'b1;
    repeat (2) @(negedge clk);
    check("rst_rdata0", bus0.rdata, 32'd0);
    check("rst_ctrl0", {29'b0, bus0.done, bus0.fault, bus0.stall}, 32'd0);
    check("rst_rdata3", bus3.rdata, 32'd0);
    check("rst_ctrl3", {29'b0, bus3.done, bus3.fault, bus3.stall}, 32'd0);
    rst0 = 1'b0; rst3 = 1'b0;

    // Zero wait states
    req(0, "sw10",     0, 1, 3'b010, 32'h10,   32'hDEADBEEF, 32'h0,        0);
    req(0, "lw10",     1, 0, 3'b010, 32'h10,   32'h0,        32'hDEADBEEF, 0);
    req(0, "sw20",     0, 1, 3'b010, 32'h20,   32'h0,        32'h0,        0);
    req(0, "sb21",     0, 1, 3'b000, 32'h21,   32'h000000F0, 32'h0,        0);
    req(0, "lb21",     1, 0, 3'b000, 32'h21,   32'h0,        32'hFFFFFFF0, 0);
    req(0, "lbu21",    1, 0, 3'b100, 32'h21,   32'h0,        32'h000000F0, 0);
    req(0, "lw20",     1, 0, 3'b010, 32'h20,   32'h0,        32'h0000F000, 0);
    req(0, "sh22",     0, 1, 3'b001, 32'h22,   32'h1234A5A5, 32'h0,        0);
    req(0, "lw20b",    1, 0, 3'b010, 32'h20,   32'h0,        32'hA5A5F000, 0);
    req(0, "lhu20",    1, 0, 3'b101, 32'h20,   32'h0,        32'h0000F000, 0);
    req(0, "lh13",     1, 0, 3'b001, 32'h13,   32'h0,        32'h0,        1);
    req(0, "lw10b",    1, 0, 3'b010, 32'h10,   32'h0,        32'hDEADBEEF, 0);
    req(0, "sw1004",   0, 1, 3'b010, 32'h1004, 32'h12345678, 32'h0,        0);
    req(0, "lw4wrap",  1, 0, 3'b010, 32'h4,    32'h0,        32'h12345678, 0);
    req(0, "rdwr4",    1, 1, 3'b010, 32'h4,    32'hFFFFFFFF, 32'h0,        1);
    req(0, "sbu4",     0, 1, 3'b100, 32'h4,    32'hFFFFFFFF, 32'h0,        1);
    req(0, "sw6mis",   0, 1, 3'b010, 32'h6,    32'hFFFFFFFF, 32'h0,        1);
    req(0, "ld011",    1, 0, 3'b011, 32'h4,    32'h0,        32'h0,        1);
    req(0, "lw4b",     1, 0, 3'b010, 32'h4,    32'h0,        32'h12345678, 0);

    // Three wait states
    req(1, "w3_sw10",  0, 1, 3'b010, 32'h10,   32'h80011234, 32'h0,        0);
    req(1, "w3_lhu12", 1, 0, 3'b101, 32'h12,   32'h0,        32'h00008001, 0);
    req(1, "w3_lh12",  1, 0, 3'b001, 32'h12,   32'h0,        32'hFFFF8001, 0);
    req(1, "w3_lb13",  1, 0, 3'b000, 32'h13,   32'h0,        32'hFFFFFF80, 0);
    req(1, "w3_sw40",  0, 1, 3'b010, 32'h40,   32'hCAFEF00D, 32'h0,        0);

    // Store aborted by reset in its second ACCESS cycle
    @(negedge clk);
    mr[1] = 1'b0; mw[1] = 1'b1; f3[1] = 3'b010; ad[1] = 32'h40; wd[1] = 32'h11111111;
    repeat (2) @(negedge clk);
    rst3 = 1'b1;
    mw[1] = 1'b0;
    #1;
    check("w3_rst_stall", {31'b0, bus3.stall}, 32'd0);
    check("w3_rst_done",  {31'b0, bus3.done}, 32'd0);
    check("w3_rst_rdata", bus3.rdata, 32'd0);
    @(negedge clk);
    rst3 = 1'b0;
    repeat (8) @(negedge clk);
    req(1, "w3_lw40",  1, 0, 3'b010, 32'h40,   32'h0,        32'hCAFEF00D, 0);

    repeat (4) @(negedge clk);
    check("q0_empty", q0.size(), 32'd0);
    check("q1_empty", q1.size(), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/data_mem_responder.md
Name: data_mem_responder

Overview:
- Data-memory end of the load/store interface driven by the main control unit.
- Consumes MemRead/MemWrite plus funct3 (access size and signedness), the ALU-computed address and the rs2 store data.
- Performs byte/half/word accesses on an internal byte-enabled synchronous RAM with a configurable number of wait states.
- Returns aligned, sign- or zero-extended load data with a stall/done handshake so a multi-cycle core can hold in place.

Parameters:
DEPTH_WORDS, 1024, number of 32-bit words in the RAM; must be a power of 2.
WAIT_STATES, 0, extra ACCESS cycles inserted before the response (0..15).

Ports:
clk  in  1  clock
rst  in  1  asynchronous, active-high reset
MemRead  in  1  load request from the control unit
MemWrite  in  1  store request from the control unit
funct3  in  3  access type: 000 LB, 001 LH, 010 LW, 100 LBU, 101 LHU; stores use 000 SB, 001 SH, 010 SW
addr  in  32  byte address (ALU result)
wdata  in  32  store data (rs2)
rdata  out  32  extended load data; valid while done=1, held until the next done
stall  out  1  core must hold the current instruction
done  out  1  one-cycle pulse that completes the access
fault  out  1  qualifies done; high for a misaligned, illegal-funct3 or read+write request

Behaviour:
- Reset (asynchronous): state=IDLE, rdata=0, done=0, fault=0, wait counter=0. RAM contents are not cleared.
- State IDLE:
  - req = MemRead | MemWrite.
  - stall = req (combinational).
  - When req=1, capture funct3, addr, wdata and the op on the clock edge.
  - Error checks at capture:
    - Misaligned: half with addr[0]=1, or word with addr[1:0]!=0.
    - Illegal funct3: store with funct3[2]=1 or 011; load with 011, 110 or 111.
    - MemRead=MemWrite=1.
  - Any error -> go to RESP with err flag set.
  - No error -> go to ACCESS with counter=WAIT_STATES.
- State ACCESS:
  - stall=1. New inputs are ignored.
  - counter>0: decrement and stay.
  - counter==0, store: assert byte enables. SB -> be=0001<<addr[1:0], data replicated. SH -> be=0011<<addr[1:0]. SW -> be=1111. RAM written at this edge.
  - counter==0, load: RAM read is issued.
  - Then go to RESP.
- State RESP:
  - stall=0, done=1, fault=err. Inputs are ignored; the core advances at this edge.
  - Next state is IDLE.
  - Load: select the byte/half by addr[1:0]/addr[1], sign-extend (LB/LH) or zero-extend (LBU/LHU).
  - Store: rdata=0.
  - Fault: rdata=0 and no RAM write ever occurs.
- Latency: an accepted request at edge T gives done in cycle T+WAIT_STATES+2. A fault gives done in cycle T+1.
- Back-to-back: a new request can be accepted in the IDLE cycle right after RESP. Max throughput is one access per WAIT_STATES+3 cycles.
- Address mapping: word index = addr[log2(DEPTH_WORDS)+1:2]. Higher bits are ignored, so accesses wrap modulo the RAM size.
- Reset mid-operation: the FSM returns to IDLE immediately and no pending done is produced.
  - Reset before the ACCESS write edge: the store is not performed.
  - Reset asserted at or after that edge: RAM keeps the written value.
- done and fault are never high outside RESP. stall and done are never high together.

Decomposition:
- Shared package mem_op_pkg:
  - mem_size_t enum (MEM_B=000, MEM_H=001, MEM_W=010, MEM_BU=100, MEM_HU=101).
  - FSM state enum (IDLE, ACCESS, RESP).
  - LOAD_OPCODE / STORE_OPCODE constants, so the control unit and this block share encodings.
- One sub-module: byte_en_ram.
  - Single-port synchronous RAM, 4 byte lanes, DEPTH_WORDS deep.
  - Registered read, per-lane write enable.
  - Infers FPGA block RAM.
- Extension/alignment logic and the FSM live in data_mem_responder.

Test Plan:
1. WAIT_STATES=0: SW addr=0x10 wdata=0xDEADBEEF, then LW addr=0x10 -> stall high 2 cycles, done at T+2, fault=0; load returns rdata=0xDEADBEEF.
2. SB addr=0x21 wdata=0x000000F0 over a word of 0; then LB 0x21 -> rdata=0xFFFFFFF0; LBU 0x21 -> 0x000000F0; LW 0x20 -> 0x0000F000.
3. LH addr=0x13 -> done at T+1, fault=1, rdata=0. A following LW 0x10 still returns the prior contents (no corruption).
4. WAIT_STATES=3, LHU addr=0x12 holding 0x8001_xxxx -> done exactly at T+5, rdata=0x00008001. Stall was high for cycles T..T+4.
5. SW addr=0x40 with WAIT_STATES=3; assert rst during the second ACCESS cycle -> immediate IDLE, no done. A later LW 0x40 returns the old value, not the store data.
6. With DEPTH_WORDS=1024: SW addr=0x1004 data=0x12345678, then LW addr=0x0004 -> 0x12345678 (wrap). MemRead=MemWrite=1 -> fault=1, no write.
